// File: rtl/dlsc_addr_router_pkg.sv
// Shared helpers for dlsc_addr_router: width derivations and target layout.
// Optional remap build: define DLSC_ADDR_ROUTER_REMAP_EN.
package dlsc_addr_router_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int calc_pb(input int ports);
    return (ports > 1) ? clog2(ports) : 1;
  endfunction

  function automatic int calc_cb(input int outstanding);
    return (outstanding > 0) ? clog2(outstanding + 1) : 1;
  endfunction

  // target = {miss, port}: port field at the bottom, miss bit above it
  localparam int TGT_PORT_LSB = 0;

  function automatic int tgt_miss_bit(input int pb);
    return pb;
  endfunction

endpackage

// File: rtl/dlsc_addr_router_match.sv
// Combinational base/mask range matcher with lowest-index priority.
// Remaps the address when DLSC_ADDR_ROUTER_REMAP_EN is defined.
module dlsc_addr_router_match
  import dlsc_addr_router_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int RANGES = 1,
  parameter int PB = 1,
  parameter logic [RANGES*ADDR-1:0] MASKS = '0,
  parameter logic [RANGES*ADDR-1:0] BASES = '0,
  parameter logic [RANGES*PB-1:0] PORT_MAP = '0
) (
  input  logic [ADDR-1:0] addr,
  output logic hit,
  output logic [calc_pb(RANGES)-1:0] idx,
  output logic [PB-1:0] port,
  output logic [ADDR-1:0] remap_addr
);

  localparam int IB = calc_pb(RANGES);

`ifdef DLSC_ADDR_ROUTER_REMAP_EN
  logic [ADDR-1:0] mask_sel;
`endif

  // Walk downward so the lowest matching index is the final winner
  always_comb begin
    hit = 1'b0;
    idx = '0;
    port = '0;
`ifdef DLSC_ADDR_ROUTER_REMAP_EN
    mask_sel = '0;
`endif
    for (int j = RANGES - 1; j >= 0; j--) begin
      if ((addr & ~MASKS[j*ADDR +: ADDR]) ==
          (BASES[j*ADDR +: ADDR] & ~MASKS[j*ADDR +: ADDR])) begin
        hit = 1'b1;
        idx = IB'(j);
        port = PORT_MAP[j*PB +: PB];
`ifdef DLSC_ADDR_ROUTER_REMAP_EN
        mask_sel = MASKS[j*ADDR +: ADDR];
`endif
      end
    end
  end

`ifdef DLSC_ADDR_ROUTER_REMAP_EN
  assign remap_addr = hit ? (addr & mask_sel) : addr;
`else
  assign remap_addr = addr;
`endif

endmodule

// File: rtl/dlsc_addr_router.sv
// Registered address router: decode, two-entry buffer, ordering gate.
// Optional address remap: define DLSC_ADDR_ROUTER_REMAP_EN.
module dlsc_addr_router
  import dlsc_addr_router_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int RANGES = 1,
  parameter int PORTS = 1,
  parameter logic [RANGES*ADDR-1:0] MASKS = '0,
  parameter logic [RANGES*ADDR-1:0] BASES = '0,
  parameter logic [RANGES*calc_pb(PORTS)-1:0] PORT_MAP = '0,
  parameter int OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic in_ready,
  input  logic in_valid,
  input  logic [ADDR-1:0] in_addr,
  input  logic out_ready,
  output logic out_valid,
  output logic [ADDR-1:0] out_addr,
  output logic [calc_pb(PORTS)-1:0] out_port,
  output logic out_miss,
  input  logic cmpl_valid,
  output logic busy
);

  localparam int PB = calc_pb(PORTS);
  localparam int CB = calc_cb(OUTSTANDING);
  localparam int TW = PB + 1;

  typedef struct packed {
    logic miss;
    logic [PB-1:0] port;
    logic [ADDR-1:0] addr;
  } entry_t;

  entry_t in_entry;
  entry_t head_q, head_n;
  entry_t skid_q, skid_n;
  logic head_v, head_vn;
  logic skid_v, skid_vn;
  logic [CB-1:0] count;
  logic [TW-1:0] last_tgt;
  logic [TW-1:0] head_tgt;
  logic m_hit;
  logic [PB-1:0] m_port;
  logic [ADDR-1:0] m_addr;
  logic accept, fire, dec, allowed;

  dlsc_addr_router_match #(
    .ADDR(ADDR),
    .RANGES(RANGES),
    .PB(PB),
    .MASKS(MASKS),
    .BASES(BASES),
    .PORT_MAP(PORT_MAP)
  ) u_match (
    .addr(in_addr),
    .hit(m_hit),
    .idx(),
    .port(m_port),
    .remap_addr(m_addr)
  );

  assign in_entry.miss = ~m_hit;
  assign in_entry.port = m_hit ? m_port : '0;
  assign in_entry.addr = m_addr;

  assign head_tgt[tgt_miss_bit(PB)] = head_q.miss;
  assign head_tgt[PB-1:TGT_PORT_LSB] = head_q.port;

  assign accept = in_valid && in_ready;
  assign allowed = (count == '0) ||
    ((count < CB'(OUTSTANDING)) && (head_tgt == last_tgt));
  assign out_valid = head_v && allowed;
  assign fire = out_valid && out_ready;
  assign dec = cmpl_valid && (count != '0);

  assign out_addr = head_q.addr;
  assign out_port = head_q.port;
  assign out_miss = head_q.miss;
  assign busy = (count != '0) || head_v || skid_v;

  // Skid only fills while the head is stalled, and drains into the head first
  always_comb begin
    head_n = head_q;
    head_vn = head_v;
    skid_n = skid_q;
    skid_vn = skid_v;
    if (!head_v || fire) begin
      if (skid_v) begin
        head_n = skid_q;
        head_vn = 1'b1;
        skid_vn = 1'b0;
      end else begin
        head_vn = accept;
        if (accept) head_n = in_entry;
      end
    end else if (accept) begin
      skid_n = in_entry;
      skid_vn = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      head_v <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      in_ready <= 1'b0;
      count <= '0;
      last_tgt <= '0;
    end else begin
      head_q <= head_n;
      head_v <= head_vn;
      skid_q <= skid_n;
      skid_v <= skid_vn;
      in_ready <= !skid_vn;
      if (fire && !dec) count <= count + 1'b1;
      else if (!fire && dec) count <= count - 1'b1;
      if (fire) last_tgt <= head_tgt;
    end
  end

endmodule

// File: tb/tb_dlsc_addr_router.sv
// Directed self-checking bench for dlsc_addr_router.
// Expected values are hand-computed from the decode table below.
module tb_dlsc_addr_router;

  localparam logic [95:0] MASKS =
    {32'h0FFF_FFFF, 32'h00FF_FFFF, 32'h0FFF_FFFF};
  localparam logic [95:0] BASES =
    {32'h2000_0000, 32'h1000_0000, 32'h1000_0000};
  localparam logic [2:0] PORT_MAP = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_ready;
  logic in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [31:0] out_addr;
  logic [0:0] out_port;
  logic out_miss;
  logic cmpl_valid = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;

  dlsc_addr_router #(
    .ADDR(32),
    .RANGES(3),
    .PORTS(2),
    .MASKS(MASKS),
    .BASES(BASES),
    .PORT_MAP(PORT_MAP),
    .OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_addr(in_addr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_addr(out_addr),
    .out_port(out_port),
    .out_miss(out_miss),
    .cmpl_valid(cmpl_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rm(input logic [31:0] a,
                                     input logic [31:0] m);
`ifdef DLSC_ADDR_ROUTER_REMAP_EN
    return a & m;
`else
    return a | (m & 32'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [31:0] a,
                          input logic p, input logic miss,
                          input logic [31:0] ea);
    in_valid = 1'b1;
    in_addr = a;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_port"}, 32'(out_port), 32'(p));
    chk({tag, "_miss"}, 32'(out_miss), 32'(miss));
    chk({tag, "_addr"}, out_addr, ea);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    cmpl_valid = 1'b1;
    tick();
    cmpl_valid = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_out_miss", 32'(out_miss), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_lo", 32'(in_ready), 32'd0);
    tick();
    chk("rel_in_ready_hi", 32'(in_ready), 32'd1);

    // single forward, priority, miss
    send_one("fwd", 32'h2000_0040, 1'b0, 1'b0,
             rm(32'h2000_0040, 32'h0FFF_FFFF));
    send_one("prio", 32'h1000_0100, 1'b1, 1'b0,
             rm(32'h1000_0100, 32'h0FFF_FFFF));
    send_one("r0only", 32'h1100_0000, 1'b1, 1'b0,
             rm(32'h1100_0000, 32'h0FFF_FFFF));
    send_one("miss", 32'h3000_0000, 1'b0, 1'b1, 32'h3000_0000);

    // backpressure: two accepts then in_ready drops
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_addr = 32'h2000_0001;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    in_addr = 32'h2000_0002;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_addr = 32'h2000_0003;
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    tick();
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk("bp_hold", out_addr, rm(32'h2000_0001, 32'h0FFF_FFFF));
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_v1", 32'(out_valid), 32'd1);
    tick();
    chk("bp_v2", 32'(out_valid), 32'd1);
    chk("bp_a2", out_addr, rm(32'h2000_0002, 32'h0FFF_FFFF));
    chk("bp_rdy_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    cmpl_valid = 1'b1;
    tick();
    tick();
    cmpl_valid = 1'b0;
    chk("bp_idle", 32'(busy), 32'd0);

    // ordering block: 3 to port 1, then one to port 0
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_addr = 32'h1100_0000;
    tick();
    in_addr = 32'h1100_0001;
    tick();
    in_addr = 32'h1100_0002;
    tick();
    in_addr = 32'h2000_0000;
    tick();
    in_valid = 1'b0;
    chk("ord_held0", 32'(out_valid), 32'd0);
    tick();
    chk("ord_held1", 32'(out_valid), 32'd0);
    cmpl_valid = 1'b1;
    tick();
    tick();
    chk("ord_held2", 32'(out_valid), 32'd0);
    tick();
    cmpl_valid = 1'b0;
    chk("ord_rel", 32'(out_valid), 32'd1);
    chk("ord_port", 32'(out_port), 32'd0);
    chk("ord_addr", out_addr, rm(32'h2000_0000, 32'h0FFF_FFFF));
    tick();
    out_ready = 1'b0;
    cmpl_valid = 1'b1;
    tick();
    cmpl_valid = 1'b0;
    chk("ord_idle", 32'(busy), 32'd0);

    // outstanding limit of 4
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr = 32'h2000_0100 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("lim_held0", 32'(out_valid), 32'd0);
    tick();
    chk("lim_held1", 32'(out_valid), 32'd0);
    cmpl_valid = 1'b1;
    in_valid = 1'b1;
    in_addr = 32'h2000_0200;
    tick();
    in_valid = 1'b0;
    chk("lim_rel", 32'(out_valid), 32'd1);
    chk("lim_rel_addr", out_addr, rm(32'h2000_0104, 32'h0FFF_FFFF));
    tick();
    cmpl_valid = 1'b0;
    chk("lim_next", 32'(out_valid), 32'd1);
    chk("lim_next_addr", out_addr, rm(32'h2000_0200, 32'h0FFF_FFFF));
    tick();
    chk("lim_full", 32'(out_valid), 32'd0);
    chk("lim_busy", 32'(busy), 32'd1);
    out_ready = 1'b0;
    cmpl_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("lim_busy3", 32'(busy), 32'd1);
    tick();
    cmpl_valid = 1'b0;
    chk("lim_idle", 32'(busy), 32'd0);

    // reset mid-flight: count=3, head and skid occupied
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_addr = 32'h2000_00C0 + 32'(i);
      tick();
    end
    out_ready = 1'b0;
    in_addr = 32'h2000_00C5;
    tick();
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_addr", out_addr, rm(32'h2000_00C4, 32'h0FFF_FFFF));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr", out_addr, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_rel_busy", 32'(busy), 32'd0);
    cmpl_valid = 1'b1;
    tick();
    cmpl_valid = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    send_one("post", 32'h1100_0010, 1'b1, 1'b0,
             rm(32'h1100_0010, 32'h0FFF_FFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
